// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generation, show-ahead frame FIFO,
// sticky overrun and saturating error counters.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              divisor,
    input  logic                          drop_bad,
    output logic                          sample_tick,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          rx_parity_err,
    input  logic                          rx_stop_err,
    input  logic                          rd_en,
    output logic [8:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          clr_status,
    output logic [CNT_W-1:0]              parity_err_cnt,
    output logic [CNT_W-1:0]              stop_err_cnt,
    output logic [1:0]                    state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_BAD   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DIV_W-1:0]   r_tick_cnt;
    logic [DIV_W-1:0]   w_term;
    logic               w_tick;
    logic [8:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [8:0]         r_last;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_par_cnt;
    logic [CNT_W-1:0]   r_stop_cnt;
    logic               r_stop_q;
    logic               w_run;
    logic               w_empty;
    logic               w_full;
    logic               w_wr_req;
    logic               w_wr;
    logic               w_pop;
    logic               w_par_inc;
    logic               w_stop_inc;
    logic               w_ovf;

    // ---------------- controller FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        unique case (r_state)
            S_IDLE: begin
                w_next = enable ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (enable) begin
                    w_next = S_RUN;
                end else if (!w_empty) begin
                    w_next = S_DRAIN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (enable) begin
                    w_next = S_RUN;
                end else if (w_empty) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_run   = (r_state == S_RUN);
    assign state_o = r_state;

    // ---------------- oversample tick ----------------
    // Compare with >= so a shrinking divisor wraps on the very next cycle.
    assign w_term = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    assign w_tick = w_run && (r_tick_cnt >= w_term);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (!w_run || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + DIV_W'(1);
        end
    end

    assign sample_tick = w_tick;

    // ---------------- FIFO ----------------
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_wr_req = w_run && rx_valid && !(drop_bad && rx_parity_err);
    assign w_pop    = rd_en && !w_empty;
    assign w_wr     = w_wr_req && (!w_full || w_pop);
    assign w_ovf    = w_wr_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {rx_parity_err, rx_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
                r_last <= r_mem[r_rptr];
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Once empty, the last popped entry stays visible on rd_data.
    assign rd_valid   = !w_empty;
    assign rd_data    = w_empty ? r_last : r_mem[r_rptr];
    assign fifo_count = r_count;

    // ---------------- status ----------------
    assign w_par_inc  = w_run && rx_valid && rx_parity_err;
    assign w_stop_inc = w_run && rx_stop_err && !r_stop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stop_q   <= 1'b0;
            r_overrun  <= 1'b0;
            r_par_cnt  <= '0;
            r_stop_cnt <= '0;
        end else begin
            r_stop_q <= rx_stop_err;
            if (clr_status) begin
                r_overrun  <= 1'b0;
                r_par_cnt  <= '0;
                r_stop_cnt <= '0;
            end else begin
                if (w_ovf) begin
                    r_overrun <= 1'b1;
                end
                if (w_par_inc && (r_par_cnt != '1)) begin
                    r_par_cnt <= r_par_cnt + CNT_W'(1);
                end
                if (w_stop_inc && (r_stop_cnt != '1)) begin
                    r_stop_cnt <= r_stop_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign overrun        = r_overrun;
    assign parity_err_cnt = r_par_cnt;
    assign stop_err_cnt   = r_stop_cnt;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] divisor;
    logic        drop_bad;
    logic        sample_tick;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_parity_err;
    logic        rx_stop_err;
    logic        rd_en;
    logic [8:0]  rd_data;
    logic        rd_valid;
    logic [3:0]  fifo_count;
    logic        overrun;
    logic        clr_status;
    logic [7:0]  parity_err_cnt;
    logic [7:0]  stop_err_cnt;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    uart_rx_ctrl #(.FIFO_DEPTH(8), .DIV_W(16), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .divisor       (divisor),
        .drop_bad      (drop_bad),
        .sample_tick   (sample_tick),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_stop_err   (rx_stop_err),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .fifo_count    (fifo_count),
        .overrun       (overrun),
        .clr_status    (clr_status),
        .parity_err_cnt(parity_err_cnt),
        .stop_err_cnt  (stop_err_cnt),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic perr);
        rx_data       = d;
        rx_parity_err = perr;
        rx_valid      = 1'b1;
        step();
        rx_valid      = 1'b0;
        rx_parity_err = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(state_o), 0);
        chk({tag, "_cnt"}, 32'(fifo_count), 0);
        chk({tag, "_valid"}, 32'(rd_valid), 0);
        chk({tag, "_data"}, 32'(rd_data), 0);
        chk({tag, "_tick"}, 32'(sample_tick), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_pcnt"}, 32'(parity_err_cnt), 0);
        chk({tag, "_scnt"}, 32'(stop_err_cnt), 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; divisor = 16'd4; drop_bad = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; rx_parity_err = 1'b0;
        rx_stop_err = 1'b0; rd_en = 1'b0; clr_status = 1'b0;
        step();
        step();
        chk_all_zero("rst");
        reset = 1'b0;

        // tick generator, divisor 4
        enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("tick4_%0d", i), 32'(sample_tick),
                32'((i % 4) == 0));
        end
        chk("run_state", 32'(state_o), 1);
        divisor = 16'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("tick0_%0d", i), 32'(sample_tick), 1);
        end
        enable = 1'b0;
        step();
        chk("idle_state", 32'(state_o), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("tick_off_%0d", i), 32'(sample_tick), 0);
        end

        // ordered FIFO
        divisor = 16'd4;
        enable = 1'b1;
        step();
        send(8'h55, 1'b0);
        chk("lat_valid", 32'(rd_valid), 1);
        chk("lat_head", 32'(rd_data), 32'h055);
        send(8'hA3, 1'b0);
        send(8'h0F, 1'b0);
        chk("ord_cnt3", 32'(fifo_count), 3);
        pop();
        chk("ord_cnt2", 32'(fifo_count), 2);
        chk("ord_head2", 32'(rd_data), 32'h0A3);
        pop();
        chk("ord_cnt1", 32'(fifo_count), 1);
        chk("ord_head3", 32'(rd_data), 32'h00F);
        pop();
        chk("ord_cnt0", 32'(fifo_count), 0);
        chk("ord_valid0", 32'(rd_valid), 0);
        chk("ord_hold", 32'(rd_data), 32'h00F);
        pop();
        chk("empty_pop_cnt", 32'(fifo_count), 0);
        chk("empty_pop_hold", 32'(rd_data), 32'h00F);

        // overrun
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
        chk("full_cnt", 32'(fifo_count), 8);
        chk("full_ovr", 32'(overrun), 1);
        chk("full_head", 32'(rd_data), 32'h001);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);
        rd_en = 1'b1;
        send(8'h0A, 1'b0);
        rd_en = 1'b0;
        chk("fullwp_cnt", 32'(fifo_count), 8);
        chk("fullwp_ovr", 32'(overrun), 0);
        chk("fullwp_head", 32'(rd_data), 32'h002);
        for (int i = 0; i < 7; i++) pop();
        chk("tail_head", 32'(rd_data), 32'h00A);
        pop();
        chk("drain_cnt", 32'(fifo_count), 0);

        // write and pop while empty
        rd_en = 1'b1;
        send(8'h77, 1'b0);
        rd_en = 1'b0;
        chk("emptywp_cnt", 32'(fifo_count), 1);
        chk("emptywp_head", 32'(rd_data), 32'h077);
        pop();

        // parity handling
        send(8'h3C, 1'b1);
        chk("par_cnt1", 32'(fifo_count), 1);
        chk("par_head", 32'(rd_data), 32'h13C);
        chk("par_err1", 32'(parity_err_cnt), 1);
        pop();
        drop_bad = 1'b1;
        send(8'h3C, 1'b1);
        drop_bad = 1'b0;
        chk("drop_cnt", 32'(fifo_count), 0);
        chk("drop_valid", 32'(rd_valid), 0);
        chk("par_err2", 32'(parity_err_cnt), 2);

        // stop-error edges and saturation
        for (int i = 0; i < 10; i++) begin
            rx_stop_err = 1'b1; step();
            rx_stop_err = 1'b0; step();
        end
        chk("stop10", 32'(stop_err_cnt), 10);
        for (int i = 0; i < 290; i++) begin
            rx_stop_err = 1'b1; step();
            rx_stop_err = 1'b0; step();
        end
        chk("stop_sat", 32'(stop_err_cnt), 255);
        chk("stop_nofifo", 32'(fifo_count), 0);
        rx_stop_err = 1'b1;
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("stop_clr", 32'(stop_err_cnt), 0);
        chk("par_clr", 32'(parity_err_cnt), 0);
        rx_stop_err = 1'b0;
        step();
        chk("stop_clr_hold", 32'(stop_err_cnt), 0);

        // drain sequence
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        enable = 1'b0;
        step();
        chk("drain_state", 32'(state_o), 2);
        send(8'h33, 1'b0);
        chk("drain_nowr", 32'(fifo_count), 2);
        chk("drain_tick", 32'(sample_tick), 0);
        pop();
        chk("drain_pop1", 32'(fifo_count), 1);
        chk("drain_head", 32'(rd_data), 32'h022);
        pop();
        chk("drain_pop2", 32'(fifo_count), 0);
        step();
        chk("drain_idle", 32'(state_o), 0);

        // asynchronous reset mid-drain
        enable = 1'b1;
        step();
        send(8'h44, 1'b1);
        send(8'h55, 1'b0);
        enable = 1'b0;
        step();
        chk("pre_rst_state", 32'(state_o), 2);
        chk("pre_rst_pcnt", 32'(parity_err_cnt), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("arst");
        step();
        reset = 1'b0;
        step();
        chk("post_rst_state", 32'(state_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
